// File: rtl/pq_coeff_regfile_if.sv
// Bus bundle for pq_coeff_regfile: parallel accelerator word port plus the
// coefficient load/unload streams. The register file uses the slave modport.
interface pq_coeff_regfile_if #(
    parameter int N_WORDS = 32,
    parameter int LANES   = 2,
    parameter int COEFF_W = 16
);
    localparam int DATA_W = LANES * COEFF_W;

    logic [N_WORDS-1:0][DATA_W-1:0] wdata_pq_i;
    logic [N_WORDS-1:0]             we_pq_i;
    logic [N_WORDS-1:0][DATA_W-1:0] rdata_pq_o;

    logic               ld_start_i;
    logic               ld_valid_i;
    logic [COEFF_W-1:0] ld_data_i;
    logic               ld_ready_o;

    logic               ul_start_i;
    logic               ul_valid_o;
    logic [COEFF_W-1:0] ul_data_o;
    logic               ul_last_o;
    logic               ul_ready_i;

    logic               abort_i;
    logic               busy_o;
    logic               done_o;

    modport slave (
        input  wdata_pq_i, we_pq_i, ld_start_i, ld_valid_i, ld_data_i,
               ul_start_i, ul_ready_i, abort_i,
        output rdata_pq_o, ld_ready_o, ul_valid_o, ul_data_o, ul_last_o,
               busy_o, done_o
    );

    modport master (
        output wdata_pq_i, we_pq_i, ld_start_i, ld_valid_i, ld_data_i,
               ul_start_i, ul_ready_i, abort_i,
        input  rdata_pq_o, ld_ready_o, ul_valid_o, ul_data_o, ul_last_o,
               busy_o, done_o
    );
endinterface

// File: rtl/pq_coeff_regfile.sv
// Polynomial-coefficient register file: parallel per-word accelerator access plus a
// one-coefficient-per-beat load/unload stream. Define PQ_RF_RESET_INDEX_EN to reset words to their coefficient index.
module pq_coeff_regfile #(
    parameter int N_WORDS = 32,
    parameter int LANES   = 2,
    parameter int COEFF_W = 16
) (
    input logic               clk,
    input logic               rst,
    pq_coeff_regfile_if.slave bus
);
    localparam int N_COEFF = N_WORDS * LANES;
    localparam int K_W     = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
    localparam int WORD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_COEFF - 1);

    typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

    state_t                        state, state_nxt;
    logic [K_W-1:0]                k, k_nxt;
    logic                          done_q, done_nxt;
    logic [LANES-1:0][COEFF_W-1:0] mem [N_WORDS];

    logic [WORD_W-1:0] word_idx;
    logic [LANE_W-1:0] lane_idx;
    logic              ld_ready, ul_valid, ld_fire, ul_fire, k_last;

    assign word_idx = WORD_W'(k / K_W'(LANES));
    assign lane_idx = LANE_W'(k % K_W'(LANES));
    assign k_last   = (k == K_LAST);

    // The accelerator owns the addressed word on a collision, so the stream stalls.
    assign ld_ready = (state == LOAD) && !bus.we_pq_i[word_idx];
    assign ul_valid = (state == UNLOAD);
    assign ld_fire  = ld_ready && bus.ld_valid_i && !bus.abort_i;
    assign ul_fire  = ul_valid && bus.ul_ready_i && !bus.abort_i;

    assign bus.ld_ready_o = ld_ready;
    assign bus.ul_valid_o = ul_valid;
    assign bus.ul_data_o  = ul_valid ? mem[word_idx][lane_idx] : '0;
    assign bus.ul_last_o  = ul_valid && k_last;
    assign bus.busy_o     = (state != IDLE);
    assign bus.done_o     = done_q;

    always_comb begin
        for (int i = 0; i < N_WORDS; i++) begin
            bus.rdata_pq_o[i] = mem[i];
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ld_start_i) begin
                    state_nxt = LOAD;
                    k_nxt     = '0;
                end else if (bus.ul_start_i) begin
                    state_nxt = UNLOAD;
                    k_nxt     = '0;
                end
            end
            LOAD, UNLOAD: begin
                if (bus.abort_i) begin
                    state_nxt = IDLE;
                    k_nxt     = '0;
                end else if (ld_fire || ul_fire) begin
                    if (k_last) begin
                        state_nxt = IDLE;
                        k_nxt     = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        k_nxt = k + K_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                k_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            done_q <= done_nxt;
        end
    end

    // A stream beat touches only its own lane; accelerator writes replace whole words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_WORDS; i++) begin
                for (int j = 0; j < LANES; j++) begin
`ifdef PQ_RF_RESET_INDEX_EN
                    mem[i][j] <= COEFF_W'(i * LANES + j);
`else
                    mem[i][j] <= '0;
`endif
                end
            end
        end else begin
            for (int i = 0; i < N_WORDS; i++) begin
                if (bus.we_pq_i[i]) begin
                    mem[i] <= bus.wdata_pq_i[i];
                end else if (ld_fire && (word_idx == WORD_W'(i))) begin
                    mem[i][lane_idx] <= bus.ld_data_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_pq_coeff_regfile.sv
// Self-checking bench for pq_coeff_regfile: reset contents, stream load/unload,
// collisions, abort/start rules and asynchronous reset mid-stream.
module tb_pq_coeff_regfile;
    localparam int N_WORDS = 32;
    localparam int LANES   = 2;
    localparam int COEFF_W = 16;
    localparam int DATA_W  = LANES * COEFF_W;
    localparam int N_COEFF = N_WORDS * LANES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [COEFF_W-1:0] model [N_WORDS][LANES];
    logic [COEFF_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    pq_coeff_regfile_if #(.N_WORDS(N_WORDS), .LANES(LANES), .COEFF_W(COEFF_W)) bus ();

    pq_coeff_regfile #(.N_WORDS(N_WORDS), .LANES(LANES), .COEFF_W(COEFF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [COEFF_W-1:0] reset_coeff(int i, int j);
`ifdef PQ_RF_RESET_INDEX_EN
        return COEFF_W'(i * LANES + j);
`else
        return '0;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] model_word(int i);
        return {model[i][1], model[i][0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.wdata_pq_i = '0;
        bus.we_pq_i    = '0;
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b0;
        bus.ld_data_i  = '0;
        bus.ul_start_i = 1'b0;
        bus.ul_ready_i = 1'b0;
        bus.abort_i    = 1'b0;
    endtask

    task automatic reset_model();
        for (int i = 0; i < N_WORDS; i++)
            for (int j = 0; j < LANES; j++)
                model[i][j] = reset_coeff(i, j);
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        #2;
        rst = 1'b0;
        tick();
    endtask

    // Fill every word with its coefficient index through the accelerator port.
    task automatic prime_pattern();
        for (int i = 0; i < N_WORDS; i++)
            for (int j = 0; j < LANES; j++)
                model[i][j] = COEFF_W'(i * LANES + j);
        bus.we_pq_i = '1;
        for (int i = 0; i < N_WORDS; i++) bus.wdata_pq_i[i] = model_word(i);
        tick();
        bus.we_pq_i = '0;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] w5;
        logic [DATA_W-1:0] w31;
        do_reset();
        settle();
`ifdef PQ_RF_RESET_INDEX_EN
        w5 = 32'h000B000A; w31 = 32'h003F003E;
`else
        w5 = '0; w31 = '0;
`endif
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.ld_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_ready: got %b want 0", bus.ld_ready_o); end
        checks++; if (bus.ul_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ul_valid: got %b want 0", bus.ul_valid_o); end
        checks++; if (bus.ul_last_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ul_last: got %b want 0", bus.ul_last_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.done_o); end
        checks++; if (bus.rdata_pq_o[5] !== w5) begin errors++; $display("[TB] FAIL reset_word5: got %h want %h", bus.rdata_pq_o[5], w5); end
        checks++; if (bus.rdata_pq_o[31] !== w31) begin errors++; $display("[TB] FAIL reset_word31: got %h want %h", bus.rdata_pq_o[31], w31); end
        for (int i = 0; i < N_WORDS; i++) begin
            checks++; if (bus.rdata_pq_o[i] !== model_word(i)) begin errors++; $display("[TB] FAIL reset_word%0d: got %h want %h", i, bus.rdata_pq_o[i], model_word(i)); end
        end
        tick();
    endtask

    task automatic test_load();
        int ready_cnt = 0;
        int done_cnt  = 0;
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        for (int k = 0; k < N_COEFF; k++) begin
            bus.ld_valid_i = 1'b1;
            bus.ld_data_i  = 16'h1000 + 16'(k);
            model[k / LANES][k % LANES] = 16'h1000 + 16'(k);
            settle();
            if (bus.ld_ready_o === 1'b1) ready_cnt++;
            if (bus.done_o !== 1'b0) done_cnt++;
            tick();
        end
        bus.ld_valid_i = 1'b0;
        settle();
        checks++; if (ready_cnt != N_COEFF) begin errors++; $display("[TB] FAIL load_ready_run: got %0d want %0d", ready_cnt, N_COEFF); end
        checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL load_early_done: got %0d want 0", done_cnt); end
        checks++; if (bus.done_o !== 1'b1) begin errors++; $display("[TB] FAIL load_done: got %b want 1", bus.done_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL load_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.ld_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL load_ready_after: got %b want 0", bus.ld_ready_o); end
        checks++; if (bus.rdata_pq_o[31] !== 32'h103F103E) begin errors++; $display("[TB] FAIL load_word31: got %h want 103f103e", bus.rdata_pq_o[31]); end
        for (int i = 0; i < N_WORDS; i++) begin
            checks++; if (bus.rdata_pq_o[i] !== model_word(i)) begin errors++; $display("[TB] FAIL load_word%0d: got %h want %h", i, bus.rdata_pq_o[i], model_word(i)); end
        end
        tick();
        settle();
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL load_done_width: got %b want 0", bus.done_o); end
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        for (int c = 0; c <= N_COEFF; c++) begin
            int kk;
            kk = (c <= 20) ? c : c - 1;
            bus.ld_valid_i = 1'b1;
            bus.ld_data_i  = 16'h1000 + 16'(kk);
            bus.we_pq_i    = '0;
            if (c == 20) begin
                bus.we_pq_i[10]    = 1'b1;
                bus.wdata_pq_i[10] = 32'hDEADBEEF;
                model[10][0] = 16'hBEEF;
                model[10][1] = 16'hDEAD;
            end else begin
                model[kk / LANES][kk % LANES] = 16'h1000 + 16'(kk);
            end
            settle();
            if (c == 20) begin
                checks++; if (bus.ld_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL coll_ready_low: got %b want 0", bus.ld_ready_o); end
            end
            if (c == 21) begin
                checks++; if (bus.ld_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL coll_ready_back: got %b want 1", bus.ld_ready_o); end
                checks++; if (bus.rdata_pq_o[10] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL coll_word10_acc: got %h want deadbeef", bus.rdata_pq_o[10]); end
            end
            if (c == 22) begin
                checks++; if (bus.rdata_pq_o[10] !== 32'hDEAD1014) begin errors++; $display("[TB] FAIL coll_word10_lane0: got %h want dead1014", bus.rdata_pq_o[10]); end
            end
            tick();
        end
        bus.ld_valid_i = 1'b0;
        settle();
        checks++; if (bus.done_o !== 1'b1) begin errors++; $display("[TB] FAIL coll_done: got %b want 1", bus.done_o); end
        checks++; if (bus.rdata_pq_o[10] !== 32'h10151014) begin errors++; $display("[TB] FAIL coll_word10_final: got %h want 10151014", bus.rdata_pq_o[10]); end
        for (int i = 0; i < N_WORDS; i++) begin
            checks++; if (bus.rdata_pq_o[i] !== model_word(i)) begin errors++; $display("[TB] FAIL coll_word%0d: got %h want %h", i, bus.rdata_pq_o[i], model_word(i)); end
        end
        tick();
    endtask

    task automatic test_unload();
        int                 popped  = 0;
        int                 cyc     = 0;
        logic               rw_done = 1'b0;
        logic               stalled = 1'b0;
        logic [COEFF_W-1:0] held    = '0;
        logic [COEFF_W-1:0] exp_d;
        logic               exp_last;
        do_reset();
        prime_pattern();
        exp_q.delete();
        bus.ul_start_i = 1'b1;
        for (int k = 0; k < N_COEFF; k++) exp_q.push_back(model[k / LANES][k % LANES]);
        tick();
        bus.ul_start_i = 1'b0;
        while (popped < N_COEFF && cyc < 300) begin
            bus.ul_ready_i = (cyc % 2 == 0);
            bus.we_pq_i    = '0;
            // Rewrite word 20 mid-stream; coefficients 40/41 must show the new value.
            if (popped == 10 && !rw_done) begin
                bus.we_pq_i[20]    = 1'b1;
                bus.wdata_pq_i[20] = 32'hABCD1234;
                model[20][0] = 16'h1234;
                model[20][1] = 16'hABCD;
                exp_q[40 - popped] = 16'h1234;
                exp_q[41 - popped] = 16'hABCD;
                rw_done = 1'b1;
            end
            settle();
            exp_last = (popped == N_COEFF - 1);
            checks++; if (bus.ul_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ul_valid beat %0d: got %b want 1", popped, bus.ul_valid_o); end
            if (stalled) begin
                checks++; if (bus.ul_data_o !== held) begin errors++; $display("[TB] FAIL ul_stall_hold beat %0d: got %h want %h", popped, bus.ul_data_o, held); end
            end
            if (bus.ul_ready_i) begin
                exp_d = exp_q.pop_front();
                checks++; if (bus.ul_data_o !== exp_d) begin errors++; $display("[TB] FAIL ul_data beat %0d: got %h want %h", popped, bus.ul_data_o, exp_d); end
                checks++; if (bus.ul_last_o !== exp_last) begin errors++; $display("[TB] FAIL ul_last beat %0d: got %b want %b", popped, bus.ul_last_o, exp_last); end
                popped++;
                stalled = 1'b0;
            end else begin
                checks++; if (bus.ul_last_o !== exp_last) begin errors++; $display("[TB] FAIL ul_last_stall beat %0d: got %b want %b", popped, bus.ul_last_o, exp_last); end
                held    = exp_q[0];
                stalled = 1'b1;
            end
            tick();
            cyc++;
        end
        bus.ul_ready_i = 1'b0;
        bus.we_pq_i    = '0;
        checks++; if (popped != N_COEFF) begin errors++; $display("[TB] FAIL ul_timeout: got %0d beats want %0d", popped, N_COEFF); end
        settle();
        checks++; if (bus.done_o !== 1'b1) begin errors++; $display("[TB] FAIL ul_done: got %b want 1", bus.done_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL ul_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.ul_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ul_valid_after: got %b want 0", bus.ul_valid_o); end
        tick();
        settle();
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL ul_done_width: got %b want 0", bus.done_o); end
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.ld_valid_i = 1'b1;
            bus.ld_data_i  = 16'h2000 + 16'(k);
            model[k / LANES][k % LANES] = 16'h2000 + 16'(k);
            tick();
        end
        bus.abort_i   = 1'b1;
        bus.ld_data_i = 16'h200A;
        tick();
        bus.abort_i    = 1'b0;
        bus.ld_valid_i = 1'b0;
        settle();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b want 0", bus.done_o); end
        for (int i = 0; i < N_WORDS; i++) begin
            checks++; if (bus.rdata_pq_o[i] !== model_word(i)) begin errors++; $display("[TB] FAIL abort_word%0d: got %h want %h", i, bus.rdata_pq_o[i], model_word(i)); end
        end
        tick();
        settle();
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_done_late: got %b want 0", bus.done_o); end
        tick();
    endtask

    task automatic test_start_rules();
        bus.ld_start_i = 1'b1;
        bus.ul_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
        bus.ul_start_i = 1'b0;
        settle();
        checks++; if (bus.ld_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL both_start_ld_ready: got %b want 1", bus.ld_ready_o); end
        checks++; if (bus.ul_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL both_start_ul_valid: got %b want 0", bus.ul_valid_o); end
        tick();
        bus.ul_start_i = 1'b1;
        tick();
        bus.ul_start_i = 1'b0;
        settle();
        checks++; if (bus.ul_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ul_start_in_load: got %b want 0", bus.ul_valid_o); end
        tick();
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = 16'h3000;
        model[0][0]    = 16'h3000;
        tick();
        bus.ld_start_i = 1'b1;
        bus.ld_data_i  = 16'h3001;
        model[0][1]    = 16'h3001;
        tick();
        bus.ld_start_i = 1'b0;
        bus.ld_valid_i = 1'b0;
        bus.abort_i    = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        settle();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rules_abort_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.rdata_pq_o[0] !== 32'h30013000) begin errors++; $display("[TB] FAIL ld_start_in_load: got %h want 30013000", bus.rdata_pq_o[0]); end
        tick();
        bus.abort_i    = 1'b1;
        bus.ul_start_i = 1'b1;
        tick();
        bus.abort_i    = 1'b0;
        bus.ul_start_i = 1'b0;
        settle();
        checks++; if (bus.ul_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_idle: got %b want 1", bus.ul_valid_o); end
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_unload();
        prime_pattern();
        bus.we_pq_i[3]    = 1'b1;
        bus.wdata_pq_i[3] = 32'h55555555;
        model[3][0] = 16'h5555;
        model[3][1] = 16'h5555;
        tick();
        bus.we_pq_i    = '0;
        bus.ul_start_i = 1'b1;
        tick();
        bus.ul_start_i = 1'b0;
        bus.ul_ready_i = 1'b1;
        repeat (5) tick();
        settle();
        checks++; if (bus.ul_data_o !== model[2][1]) begin errors++; $display("[TB] FAIL pre_rst_data: got %h want %h", bus.ul_data_o, model[2][1]); end
        rst = 1'b1;
        reset_model();
        #1;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.ul_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ul_valid: got %b want 0", bus.ul_valid_o); end
        checks++; if (bus.ul_last_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ul_last: got %b want 0", bus.ul_last_o); end
        checks++; if (bus.ld_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ld_ready: got %b want 0", bus.ld_ready_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done: got %b want 0", bus.done_o); end
        for (int i = 0; i < N_WORDS; i++) begin
            checks++; if (bus.rdata_pq_o[i] !== model_word(i)) begin errors++; $display("[TB] FAIL rst_mid_word%0d: got %h want %h", i, bus.rdata_pq_o[i], model_word(i)); end
        end
        bus.ul_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        prime_pattern();
        bus.ul_start_i = 1'b1;
        tick();
        bus.ul_start_i = 1'b0;
        bus.ul_ready_i = 1'b1;
        settle();
        checks++; if (bus.ul_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL restart_valid: got %b want 1", bus.ul_valid_o); end
        checks++; if (bus.ul_data_o !== model[0][0]) begin errors++; $display("[TB] FAIL restart_beat0: got %h want %h", bus.ul_data_o, model[0][0]); end
        tick();
        settle();
        checks++; if (bus.ul_data_o !== model[0][1]) begin errors++; $display("[TB] FAIL restart_beat1: got %h want %h", bus.ul_data_o, model[0][1]); end
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i    = 1'b0;
        bus.ul_ready_i = 1'b0;
        settle();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL restart_abort_busy: got %b want 0", bus.busy_o); end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load();
        test_collision();
        test_unload();
        test_abort();
        test_start_rules();
        test_reset_mid_unload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/pq_coeff_regfile.md
# pq_coeff_regfile

Parametrised polynomial-coefficient register file for the PQ accelerators, the successor to the fixed 32×32-bit PQ register file. It exposes every word in parallel to an accelerator such as the NTT core, with a per-word write enable. It adds a sequential coefficient stream port that loads or unloads a whole polynomial one coefficient per beat under valid/ready handshakes. The block sits between the core-side data mover and the PQ accelerators.

## Interface
- N_WORDS, 32, number of register words
- LANES, 2, coefficients packed per word; lane j occupies bits [j*COEFF_W +: COEFF_W]
- COEFF_W, 16, coefficient width; DATA_W = LANES*COEFF_W
- N_COEFF (derived), N_WORDS*LANES; the stream counter width is clog2(N_COEFF)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wdata_pq_i  in  N_WORDS×DATA_W  accelerator write data, one per word
- we_pq_i  in  N_WORDS  accelerator per-word write enable
- rdata_pq_o  out  N_WORDS×DATA_W  all register words, registered contents
- ld_start_i  in  1  begin stream load (IDLE only)
- ld_valid_i  in  1  load beat valid
- ld_data_i  in  COEFF_W  load coefficient
- ld_ready_o  out  1  load beat accepted when high together with ld_valid_i
- ul_start_i  in  1  begin stream unload (IDLE only)
- ul_valid_o  out  1  unload beat valid
- ul_data_o  out  COEFF_W  unload coefficient
- ul_last_o  out  1  high with coefficient N_COEFF-1
- ul_ready_i  in  1  unload sink ready
- abort_i  in  1  terminate the active stream
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse after a completed stream

## Operation
- FSM states: IDLE, LOAD, UNLOAD. Counter k runs 0..N_COEFF-1. Coefficient k maps to word k/LANES, lane k%LANES.
- IDLE→LOAD on ld_start_i. IDLE→UNLOAD on ul_start_i. If both are asserted in the same cycle, LOAD wins. Starts outside IDLE are ignored. Entering either stream state clears k to 0.
- LOAD:
  - ld_ready_o = !we_pq_i[k/LANES].
  - On a handshake, the beat writes only lane k%LANES; the other lanes are untouched. k then increments.
  - Collisions: the accelerator write always wins and the stream stalls.
- UNLOAD:
  - ul_valid_o = 1.
  - ul_data_o = combinational mux of the current contents of word k/LANES, lane k%LANES.
  - k advances on ul_valid_o && ul_ready_i.
  - Accelerator writes stay legal during unload, and later beats reflect them.
- Completion:
  - On the handshake with k = N_COEFF-1, the FSM returns to IDLE and k = 0.
  - done_o = 1 for exactly the next cycle.
- abort_i in LOAD or UNLOAD: IDLE on the next edge, no done_o pulse, and no beat is accepted in that cycle. abort_i in IDLE is ignored.
- Accelerator writes: a word with we_pq_i = 1 takes wdata_pq_i on the next edge in any state.

## Timing
- Reset (asynchronous, immediate):
  - FSM = IDLE, k = 0.
  - ld_ready_o, ul_valid_o, ul_last_o, busy_o, done_o = 0.
  - Memory is initialised as described in Configuration.
- Throughput and latency:
  - One beat per cycle in both directions with no bubbles.
  - A full stream takes N_COEFF cycles when unstalled.
  - ld_ready_o first rises the cycle after ld_start_i. ul_valid_o first rises the cycle after ul_start_i.
- Write visibility: a load beat written at edge t is visible on rdata_pq_o after t.
- Backpressure: ul_data_o and ul_last_o are stable while ul_valid_o && !ul_ready_i, unless the accelerator rewrites the addressed word.
- Reset mid-stream aborts without a done_o pulse.

## Configuration
- PQ_RF_RESET_INDEX_EN defined: at reset, lane j of word i = (i*LANES + j) truncated to COEFF_W. For the defaults, word l = {2l+1, 2l}.
- PQ_RF_RESET_INDEX_EN undefined: all words reset to 0.

## Test plan
- Reset with the macro, defaults -> rdata_pq_o[5] = 0x000B000A and rdata_pq_o[31] = 0x003F003E. Without the macro, all words = 0.
- ld_start_i, then 64 beats of 0x1000+k with ld_valid_i held high -> ld_ready_o high for 64 consecutive cycles, rdata_pq_o[31] = 0x103F103E, one done_o pulse, busy_o low.
- Collision: during a load at k = 20, assert we_pq_i[10] with data 0xDEADBEEF -> ld_ready_o = 0 that cycle. Word 10 then reads 0xDEADBEEF, then 0xDEAD1014, then finally 0x10151014.
- Unload after reset with the macro, ul_ready_i toggling 1,0,1,0 -> ul_data_o sequence 0..63 in order, data held stable while stalled, ul_last_o only at 63, done_o one cycle after the last handshake.
- Abort and start rules:
  - Load 10 beats, then abort_i -> busy_o = 0 next cycle, no done_o, words 0–4 updated, words 5–31 unchanged.
  - ul_start_i while busy_o = 1 -> ignored.
  - ld_start_i and ul_start_i together -> enters LOAD.
- Assert rst mid-unload -> all outputs 0 immediately and memory re-initialised. After release, ul_start_i restarts an unload at coefficient 0.
